// File: rtl/uart_tx_buf.sv
// uart_tx_buf: UART transmitter with a one-byte holding buffer.
// Serializes each accepted byte LSB-first as start, 8 data bits, optional
// parity and 1 or 2 stop bits. The holding register allows the next byte to be
// queued while a frame shifts out, so consecutive frames run with no idle gap.
//
// Ports:
//   clk  - system clock, rising-edge
//   rst  - asynchronous reset, active-high
//   in   - byte to transmit, captured when a write is accepted
//   wr   - write strobe, accepted when the holding buffer is empty
//   out  - serial line, idles high
//   full - holding buffer occupied (writes are dropped while set)
//   busy - combinational: frame in progress or holding buffer occupied
module uart_tx_buf #(
    parameter int unsigned DIV    = 1,
    parameter int unsigned PARITY = 0,
    parameter int unsigned STOP   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in,
    input  logic       wr,
    output logic       out,
    output logic       full,
    output logic       busy
);

    localparam int unsigned   CW         = $clog2(DIV) + 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
    localparam logic          PAR_EN     = (PARITY == 1) || (PARITY == 2);
    localparam logic          PAR_ODD    = (PARITY == 2);
    localparam logic [2:0]    STOP_LAST  = (STOP == 2) ? 3'd1 : 3'd0;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic [2:0]    r_state, w_state;
    logic [CW-1:0] r_cnt,   w_cnt;
    logic [2:0]    r_bit,   w_bit;
    logic [7:0]    r_shift, w_shift;
    logic [7:0]    r_hold,  w_hold;
    logic          r_full,  w_full;
    logic          r_out,   w_out;
    logic          r_par,   w_par;
    logic          w_tick;
    logic          w_load;

    // Last cycle of the current serial bit
    assign w_tick = (r_cnt == CNT_LAST);

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_hold  <= 8'd0;
            r_full  <= 1'b0;
            r_out   <= 1'b1;
            r_par   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_bit   <= w_bit;
            r_shift <= w_shift;
            r_hold  <= w_hold;
            r_full  <= w_full;
            r_out   <= w_out;
            r_par   <= w_par;
        end
    end

    // Next-state, write acceptance and serial output
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_bit   = r_bit;
        w_shift = r_shift;
        w_hold  = r_hold;
        w_full  = r_full;
        w_out   = r_out;
        w_par   = r_par;
        w_load  = 1'b0;

        if (r_state != S_IDLE) begin
            w_cnt = w_tick ? '0 : r_cnt + CW'(1);
        end

        // Acceptance is gated on the registered full flag only
        if (wr && !r_full) begin
            w_hold = in;
            w_full = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                w_out = 1'b1;
                if (r_full) begin
                    w_load = 1'b1;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_state = S_DATA;
                    w_out   = r_shift[0];
                    w_bit   = 3'd0;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (r_bit == 3'd7) begin
                        w_bit = 3'd0;
                        if (PAR_EN) begin
                            w_state = S_PAR;
                            w_out   = r_par;
                        end else begin
                            w_state = S_STOP;
                            w_out   = 1'b1;
                        end
                    end else begin
                        w_shift = {1'b0, r_shift[7:1]};
                        w_out   = r_shift[1];
                        w_bit   = r_bit + 3'd1;
                    end
                end
            end
            S_PAR: begin
                if (w_tick) begin
                    w_state = S_STOP;
                    w_out   = 1'b1;
                    w_bit   = 3'd0;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (r_bit == STOP_LAST) begin
                        // Back-to-back: go straight to the next start bit
                        if (r_full) begin
                            w_load = 1'b1;
                        end else begin
                            w_state = S_IDLE;
                            w_out   = 1'b1;
                            w_bit   = 3'd0;
                        end
                    end else begin
                        w_bit = r_bit + 3'd1;
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
                w_out   = 1'b1;
                w_cnt   = '0;
                w_bit   = 3'd0;
            end
        endcase

        // Holding-to-shifter transfer; parity is fixed for the whole frame here
        if (w_load) begin
            w_shift = r_hold;
            w_par   = (^r_hold) ^ PAR_ODD;
            w_full  = 1'b0;
            w_state = S_START;
            w_out   = 1'b0;
            w_cnt   = '0;
            w_bit   = 3'd0;
        end
    end

    assign out  = r_out;
    assign full = r_full;
    assign busy = (r_state != S_IDLE) || r_full;

endmodule

// File: tb/tb_uart_tx_buf.sv
// tb_uart_tx_buf: directed, table-driven bench for uart_tx_buf.
// Three instances: u0 defaults, u1 DIV=4/even parity/2 stop, u2 odd parity.
module tb_uart_tx_buf;

    logic       clk;
    logic       rst;
    logic [7:0] in0, in1, in2;
    logic       wr0, wr1, wr2;
    logic       out0, out1, out2;
    logic       full0, full1, full2;
    logic       busy0, busy1, busy2;

    int n_checks;
    int n_errors;

    uart_tx_buf u0 (
        .clk(clk), .rst(rst), .in(in0), .wr(wr0),
        .out(out0), .full(full0), .busy(busy0)
    );

    uart_tx_buf #(.DIV(4), .PARITY(1), .STOP(2)) u1 (
        .clk(clk), .rst(rst), .in(in1), .wr(wr1),
        .out(out1), .full(full1), .busy(busy1)
    );

    uart_tx_buf #(.DIV(1), .PARITY(2), .STOP(1)) u2 (
        .clk(clk), .rst(rst), .in(in2), .wr(wr2),
        .out(out2), .full(full2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] din;
        logic [9:0] frame;   // bit i is the i-th bit on the line
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] obs(input int sel);
        case (sel)
            0:       return {out0, full0, busy0};
            1:       return {out1, full1, busy1};
            default: return {out2, full2, busy2};
        endcase
    endfunction

    task automatic drive(input int sel, input logic [7:0] d, input logic w);
        case (sel)
            0:       begin in0 = d; wr0 = w; end
            1:       begin in1 = d; wr1 = w; end
            default: begin in2 = d; wr2 = w; end
        endcase
    endtask

    // Write one byte from idle and check the whole frame, sampled every cycle.
    task automatic send(input int sel, input logic [7:0] d, input logic [11:0] bits,
                        input int nbits, input int div, input string name);
        logic [63:0] got;
        logic [63:0] exp;
        logic [2:0]  o;
        int          busy_bad;
        got      = '0;
        exp      = '0;
        busy_bad = 0;
        drive(sel, d, 1'b1);
        @(negedge clk);
        o = obs(sel);
        chk({name, " accept out/full/busy"}, 64'(o), 64'(3'b111));
        drive(sel, ~d, 1'b0);
        for (int i = 0; i < nbits * div; i++) begin
            @(negedge clk);
            o = obs(sel);
            got[i] = o[2];
            exp[i] = bits[i / div];
            if (!o[0]) busy_bad++;
            if (i == 0) chk({name, " full one cycle"}, 64'(o[1]), 64'(1'b0));
        end
        chk({name, " frame"}, got, exp);
        chk({name, " busy during frame"}, 64'(busy_bad), 64'(0));
        @(negedge clk);
        o = obs(sel);
        chk({name, " idle after"}, 64'(o), 64'(3'b100));
    endtask

    initial begin
        logic [19:0] got20;
        logic [2:0]  o;

        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        in0 = 8'h00; in1 = 8'h00; in2 = 8'h00;
        wr0 = 1'b0;  wr1 = 1'b0;  wr2 = 1'b0;

        // {stop, data[7:0], start}
        tbl[0] = '{8'h55, 10'b1_01010101_0};
        tbl[1] = '{8'h00, 10'b1_00000000_0};
        tbl[2] = '{8'hFF, 10'b1_11111111_0};
        tbl[3] = '{8'hA3, 10'b1_10100011_0};
        tbl[4] = '{8'h0F, 10'b1_00001111_0};
        tbl[5] = '{8'h80, 10'b1_10000000_0};
        tbl[6] = '{8'h01, 10'b1_00000001_0};

        #2;
        chk("reset u0", 64'(obs(0)), 64'(3'b100));
        chk("reset u1", 64'(obs(1)), 64'(3'b100));
        chk("reset u2", 64'(obs(2)), 64'(3'b100));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 7; k++) begin
            send(0, tbl[k].din, {2'b00, tbl[k].frame}, 10, 1, $sformatf("tbl%0d", k));
        end

        // Back-to-back 0xA3 then 0x0F, with an overflow write of 0xFF held high
        drive(0, 8'hA3, 1'b1);
        @(negedge clk);
        chk("b2b first accept full", 64'(full0), 64'(1'b1));
        drive(0, 8'h00, 1'b0);
        got20 = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            got20[i] = out0;
            if (i == 0) begin
                chk("b2b full cleared", 64'(full0), 64'(1'b0));
                drive(0, 8'h0F, 1'b1);
            end
            if (i == 1) begin
                chk("b2b second accept", 64'(full0), 64'(1'b1));
                drive(0, 8'hFF, 1'b1);
            end
            if (i == 6) drive(0, 8'hFF, 1'b0);
            if (i == 9) chk("overflow full held", 64'(full0), 64'(1'b1));
            if (i == 10) chk("b2b reload clears full", 64'(full0), 64'(1'b0));
        end
        chk("b2b 20 bits", 64'(got20), 64'({10'b1_00001111_0, 10'b1_10100011_0}));
        got20 = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            got20[i] = out0 & ~busy0;
        end
        chk("overflow byte dropped", 64'(got20), 64'(20'h003FF));

        // Even parity, 2 stop bits, DIV=4: {stop, stop, par, data, start}
        send(1, 8'h07, 12'b11_1_00000111_0, 12, 4, "p1s2d4 07");

        // Odd parity
        send(2, 8'h03, {1'b0, 11'b1_1_00000011_0}, 11, 1, "odd 03");
        send(2, 8'h01, {1'b0, 11'b1_0_00000001_0}, 11, 1, "odd 01");

        // Reset mid-frame during data bit 3 of 0x00
        drive(0, 8'h00, 1'b1);
        @(negedge clk);
        drive(0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) @(negedge clk);
        chk("pre-reset data bit3", 64'(obs(0)), 64'(3'b001));
        rst = 1'b1;
        #1;
        o = obs(0);
        chk("async reset mid-frame", 64'(o), 64'(3'b100));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("after reset idle", 64'(obs(0)), 64'(3'b100));
        send(0, 8'hC4, {2'b00, 10'b1_11000100_0}, 10, 1, "post-reset C4");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
